// File: rtl/sprite_pkg.sv
// Shared constants for the bouncing-sprite block: FSM encodings and a width helper.
package sprite_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAW  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ERASE = 3'd3;
    localparam logic [2:0] ST_MOVE  = 3'd4;

    // Ceiling log2, floored at 1 so the result can always size a vector.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sprite_bouncer_if.sv
// Pixel-write and sprite-ROM signals shared by the bouncer and its VGA/ROM side.
interface sprite_bouncer_if #(
    parameter int AW = 6,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
) ();
    // plot is a one-way write strobe with no backpressure: x/y/colour are meaningful
    // only in cycles where plot is high. rom_data answers rom_addr one clock later.
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;

    modport master (
        output rom_addr,
        input  rom_data,
        output x,
        output y,
        output colour,
        output plot
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  x,
        input  y,
        input  colour,
        input  plot
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Step tick: one-cycle pulse every TICK_DIV*FRAMES_PER_STEP clocks, free-running.
module frame_tick_gen
    import sprite_pkg::*;
#(
    parameter int TICK_DIV        = 833334,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);
    localparam int DW = clog2(TICK_DIV);
    localparam int FW = clog2(FRAMES_PER_STEP);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES_PER_STEP - 1);

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frm_cnt;
    logic          div_wrap;
    logic          frm_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign frm_wrap = (frm_cnt == FRM_LAST);
    assign tick     = div_wrap && frm_wrap;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            frm_cnt <= '0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                frm_cnt <= frm_wrap ? '0 : frm_cnt + FW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/sprite_bouncer.sv
// Bouncing sprite: erases the sprite, steps it one pixel diagonally with edge
// reflection, then redraws it from an external synchronous sprite ROM.
module sprite_bouncer
    import sprite_pkg::*;
#(
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int SPR_W           = 8,
    parameter int SPR_H           = 8,
    parameter int COLOUR_BITS     = 3,
    parameter int TICK_DIV        = 833334,
    parameter int FRAMES_PER_STEP = 4,
    parameter int X0              = 0,
    parameter int Y0              = 60,
    parameter int TRANSPARENT     = 0,
    localparam int XW = clog2(SCREEN_W),
    localparam int YW = clog2(SCREEN_H)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [COLOUR_BITS-1:0] bg_colour,
    output logic                   busy,
    sprite_bouncer_if.master       bus,
    output logic [2:0]             fsm_state,
    output logic [XW-1:0]          pos_x,
    output logic [YW-1:0]          pos_y,
    output logic                   dir_right,
    output logic                   dir_down
);
    localparam int AW  = clog2(SPR_W * SPR_H);
    localparam int CLW = clog2(SPR_W);
    localparam int RLW = clog2(SPR_H);
    localparam logic [CLW-1:0] COL_LAST = CLW'(SPR_W - 1);
    localparam logic [RLW-1:0] ROW_LAST = RLW'(SPR_H - 1);
    localparam logic [XW-1:0]  X_MAX    = XW'(SCREEN_W - SPR_W);
    localparam logic [YW-1:0]  Y_MAX    = YW'(SCREEN_H - SPR_H);
    localparam bit             X_FIXED  = (SCREEN_W == SPR_W);
    localparam bit             Y_FIXED  = (SCREEN_H == SPR_H);
    localparam logic [COLOUR_BITS-1:0] TRANSP = COLOUR_BITS'(TRANSPARENT);

    logic           step_tick;
    logic [CLW-1:0] col;
    logic [RLW-1:0] row;
    logic [CLW-1:0] col_nx;
    logic [RLW-1:0] row_nx;
    logic           last_px;
    logic           issue_done;
    logic           draw_px;
    logic           erase_px;

    frame_tick_gen #(
        .TICK_DIV        (TICK_DIV),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (step_tick)
    );

    assign last_px = (col == COL_LAST) && (row == ROW_LAST);
    assign col_nx  = (col == COL_LAST) ? '0 : col + CLW'(1);
    assign row_nx  = (col == COL_LAST) ? row + RLW'(1) : row;

    // DRAW output pixels carry ROM data straight through, so the ROM's one-cycle
    // read latency lines up with the registered coordinates.
    assign bus.plot   = draw_px ? (bus.rom_data != TRANSP) : erase_px;
    assign bus.colour = draw_px ? bus.rom_data : (erase_px ? bg_colour : '0);
    assign busy       = (fsm_state == ST_DRAW) || (fsm_state == ST_ERASE) ||
                        (fsm_state == ST_MOVE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_state    <= ST_IDLE;
            pos_x        <= XW'(X0);
            pos_y        <= YW'(Y0);
            dir_right    <= 1'b1;
            dir_down     <= 1'b0;
            col          <= '0;
            row          <= '0;
            issue_done   <= 1'b0;
            draw_px      <= 1'b0;
            erase_px     <= 1'b0;
            bus.rom_addr <= '0;
            bus.x        <= '0;
            bus.y        <= '0;
        end else begin
            case (fsm_state)
                ST_IDLE: fsm_state <= ST_DRAW;

                ST_DRAW: begin
                    if (!issue_done) begin
                        bus.x   <= pos_x + XW'(col);
                        bus.y   <= pos_y + YW'(row);
                        draw_px <= 1'b1;
                        if (last_px) begin
                            issue_done <= 1'b1;
                        end else begin
                            col          <= col_nx;
                            row          <= row_nx;
                            bus.rom_addr <= bus.rom_addr + AW'(1);
                        end
                    end else begin
                        // Scan counters return to zero so the next scan starts clean.
                        draw_px      <= 1'b0;
                        issue_done   <= 1'b0;
                        col          <= '0;
                        row          <= '0;
                        bus.rom_addr <= '0;
                        fsm_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (step_tick && enable) begin
                        bus.x     <= pos_x;
                        bus.y     <= pos_y;
                        erase_px  <= 1'b1;
                        fsm_state <= ST_ERASE;
                    end
                end

                ST_ERASE: begin
                    if (last_px) begin
                        erase_px  <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        fsm_state <= ST_MOVE;
                    end else begin
                        col   <= col_nx;
                        row   <= row_nx;
                        bus.x <= pos_x + XW'(col_nx);
                        bus.y <= pos_y + YW'(row_nx);
                    end
                end

                ST_MOVE: begin
                    // A boundary hit reverses direction and steps back in the same move.
                    if (!X_FIXED) begin
                        if (dir_right) begin
                            if (pos_x == X_MAX) begin
                                dir_right <= 1'b0;
                                pos_x     <= pos_x - XW'(1);
                            end else begin
                                pos_x <= pos_x + XW'(1);
                            end
                        end else begin
                            if (pos_x == '0) begin
                                dir_right <= 1'b1;
                                pos_x     <= pos_x + XW'(1);
                            end else begin
                                pos_x <= pos_x - XW'(1);
                            end
                        end
                    end
                    if (!Y_FIXED) begin
                        if (dir_down) begin
                            if (pos_y == Y_MAX) begin
                                dir_down <= 1'b0;
                                pos_y    <= pos_y - YW'(1);
                            end else begin
                                pos_y <= pos_y + YW'(1);
                            end
                        end else begin
                            if (pos_y == '0) begin
                                dir_down <= 1'b1;
                                pos_y    <= pos_y + YW'(1);
                            end else begin
                                pos_y <= pos_y - YW'(1);
                            end
                        end
                    end
                    fsm_state <= ST_DRAW;
                end

                default: fsm_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_bouncer.sv
// Directed bench for sprite_bouncer: draw/erase timing, bounces, transparency,
// enable gating and mid-erase reset, with hand-computed cycle expectations.
module tb_sprite_bouncer;
    import sprite_pkg::*;

    localparam int TD  = 25;
    localparam int FPS = 4;
    localparam int AW  = 6;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int CW  = 3;

    // clock / reset
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic          enable;
    logic [CW-1:0] bg_colour;
    logic          hole_en;
    logic          busy_a, busy_b;
    logic [2:0]    state_a, state_b;
    logic [XW-1:0] pos_x_a, pos_x_b;
    logic [YW-1:0] pos_y_a, pos_y_b;
    logic          dir_right_a, dir_right_b, dir_down_a, dir_down_b;
    int            cyc;
    int            checks = 0;
    int            failures = 0;

    sprite_bouncer_if #(.AW(AW), .XW(XW), .YW(YW), .CW(CW)) bus_a ();
    sprite_bouncer_if #(.AW(AW), .XW(XW), .YW(YW), .CW(CW)) bus_b ();

    sprite_bouncer #(.TICK_DIV(TD), .FRAMES_PER_STEP(FPS)) dut_a (
        .clock(clock), .resetn(resetn), .enable(enable), .bg_colour(bg_colour),
        .busy(busy_a), .bus(bus_a), .fsm_state(state_a), .pos_x(pos_x_a),
        .pos_y(pos_y_a), .dir_right(dir_right_a), .dir_down(dir_down_a)
    );

    sprite_bouncer #(.TICK_DIV(TD), .FRAMES_PER_STEP(FPS), .X0(152), .Y0(0)) dut_b (
        .clock(clock), .resetn(resetn), .enable(enable), .bg_colour(bg_colour),
        .busy(busy_b), .bus(bus_b), .fsm_state(state_b), .pos_x(pos_x_b),
        .pos_y(pos_y_b), .dir_right(dir_right_b), .dir_down(dir_down_b)
    );

    // sprite ROMs: all 7, with pixel 9 transparent on A once hole_en is set
    always @(posedge clock) begin
        bus_a.rom_data <= (hole_en && bus_a.rom_addr == 6'd9) ? 3'd0 : 3'd7;
        bus_b.rom_data <= 3'd7;
    end

    // edges since the last reset release
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after edge e
    task automatic go_to(input int e);
        int guard;
        guard = 0;
        while (cyc < e && guard < 1000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (cyc != e) check("sync_timeout", cyc, e);
    endtask

    initial begin
        enable    = 1'b1;
        bg_colour = 3'd5;
        hole_en   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state_a", state_a, ST_IDLE);
        check("rst_plot_a", bus_a.plot, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_x_a", bus_a.x, 0);
        check("rst_y_a", bus_a.y, 0);
        check("rst_colour_a", bus_a.colour, 0);
        check("rst_addr_a", bus_a.rom_addr, 0);
        check("rst_pos_x_a", pos_x_a, 0);
        check("rst_pos_y_a", pos_y_a, 60);
        check("rst_dir_a", {dir_right_a, dir_down_a}, 2'b10);
        check("rst_pos_x_b", pos_x_b, 152);
        check("rst_pos_y_b", pos_y_b, 0);

        @(negedge clock) resetn = 1'b1;

        go_to(1);
        check("draw0_state", state_a, ST_DRAW);
        check("draw0_busy", busy_a, 1);
        check("draw0_plot_first", bus_a.plot, 0);
        for (int k = 0; k < 64; k++) begin
            go_to(k + 2);
            check($sformatf("draw0_plot[%0d]", k), bus_a.plot, 1);
            check($sformatf("draw0_x[%0d]", k), bus_a.x, k % 8);
            check($sformatf("draw0_y[%0d]", k), bus_a.y, 60 + k / 8);
            check($sformatf("draw0_col[%0d]", k), bus_a.colour, 7);
        end
        go_to(66);
        check("draw0_busy_fall", busy_a, 0);
        check("draw0_plot_off", bus_a.plot, 0);
        check("wait_state", state_a, ST_WAIT);
        go_to(99);
        check("wait_before_tick", state_a, ST_WAIT);
        hole_en = 1'b1;

        go_to(100);
        check("erase_state", state_a, ST_ERASE);
        check("erase_plot0", bus_a.plot, 1);
        check("erase_x0", bus_a.x, 0);
        check("erase_y0", bus_a.y, 60);
        check("erase_colour0", bus_a.colour, 5);
        go_to(163);
        check("erase_x63", bus_a.x, 7);
        check("erase_y63", bus_a.y, 67);
        check("erase_plot63", bus_a.plot, 1);
        go_to(164);
        check("move_state", state_a, ST_MOVE);
        check("move_plot", bus_a.plot, 0);
        check("move_busy", busy_a, 1);

        go_to(165);
        check("move_pos_x_a", pos_x_a, 1);
        check("move_pos_y_a", pos_y_a, 59);
        check("move_dir_a", {dir_right_a, dir_down_a}, 2'b10);
        check("corner_pos_x_b", pos_x_b, 151);
        check("corner_pos_y_b", pos_y_b, 1);
        check("corner_dir_b", {dir_right_b, dir_down_b}, 2'b01);
        check("redraw_state_a", state_a, ST_DRAW);
        for (int k = 0; k < 64; k++) begin
            go_to(166 + k);
            check($sformatf("hole_plot[%0d]", k), bus_a.plot, (k != 9) ? 1 : 0);
            if (k == 9) begin
                check("hole_x", bus_a.x, 2);
                check("hole_y", bus_a.y, 60);
            end
            if (k == 0) begin
                check("corner_draw_x0", bus_b.x, 151);
                check("corner_draw_y0", bus_b.y, 1);
                check("corner_draw_plot0", bus_b.plot, 1);
            end
            if (k == 63) begin
                check("corner_draw_x63", bus_b.x, 158);
                check("corner_draw_y63", bus_b.y, 8);
            end
        end
        go_to(230);
        check("redraw_done", state_a, ST_WAIT);
        enable = 1'b0;

        go_to(300);
        check("dis_state_300", state_a, ST_WAIT);
        check("dis_plot_300", bus_a.plot, 0);
        go_to(400);
        check("dis_state_400", state_a, ST_WAIT);
        check("dis_plot_400", bus_a.plot, 0);
        check("dis_busy_400", busy_a, 0);
        go_to(450);
        enable    = 1'b1;
        bg_colour = 3'd2;
        go_to(499);
        check("reen_wait", state_a, ST_WAIT);
        go_to(500);
        check("reen_state", state_a, ST_ERASE);
        check("reen_plot", bus_a.plot, 1);
        check("reen_colour", bus_a.colour, 2);
        check("reen_x", bus_a.x, 1);
        check("reen_y", bus_a.y, 59);

        go_to(530);
        check("pre_rst_plot", bus_a.plot, 1);
        resetn = 1'b0;
        #1;
        check("midrst_plot", bus_a.plot, 0);
        check("midrst_state", state_a, ST_IDLE);
        check("midrst_busy", busy_a, 0);
        check("midrst_x", bus_a.x, 0);
        check("midrst_colour", bus_a.colour, 0);
        check("midrst_pos_x", pos_x_a, 0);
        check("midrst_pos_y", pos_y_a, 60);
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1'b1;
        go_to(1);
        check("restart_state", state_a, ST_DRAW);
        go_to(2);
        check("restart_plot0", bus_a.plot, 1);
        check("restart_x0", bus_a.x, 0);
        check("restart_y0", bus_a.y, 60);
        go_to(11);
        check("restart_hole_plot", bus_a.plot, 0);
        check("restart_hole_x", bus_a.x, 1);
        check("restart_hole_y", bus_a.y, 61);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_bouncer.md
SPRITE_BOUNCER -- requirements
Module: sprite_bouncer

Interface
REQ-001 SHALL have parameter SCREEN_W, 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, 120, screen height in pixels.
REQ-003 SHALL have parameter SPR_W, 8, sprite width in pixels; range 1..SCREEN_W.
REQ-004 SHALL have parameter SPR_H, 8, sprite height in pixels; range 1..SCREEN_H.
REQ-005 SHALL have parameter COLOUR_BITS, 3, bits per pixel colour.
REQ-006 SHALL have parameter TICK_DIV, 833334, clock cycles per frame tick (60 Hz at 50 MHz).
REQ-007 SHALL have parameter FRAMES_PER_STEP, 4, frame ticks per one-pixel move.
REQ-008 SHALL have parameter X0, 0, reset x position; must be 0..SCREEN_W-SPR_W.
REQ-009 SHALL have parameter Y0, 60, reset y position; must be 0..SCREEN_H-SPR_H.
REQ-010 SHALL have parameter TRANSPARENT, 0, sprite colour that is not plotted.
REQ-011 clock  in  1  system clock; single clock domain.
REQ-012 resetn  in  1  asynchronous, active-low reset.
REQ-013 enable  in  1  motion enable; sampled in WAIT.
REQ-014 bg_colour  in  COLOUR_BITS  colour used to erase the old sprite.
REQ-015 rom_addr  out  AW=clog2(SPR_W*SPR_H)  sprite ROM address, row-major.
REQ-016 rom_data  in  COLOUR_BITS  ROM output, valid one clock after rom_addr (synchronous ROM on clock).
REQ-017 x  out  XW=clog2(SCREEN_W)  pixel x to VGA adapter.
REQ-018 y  out  YW=clog2(SCREEN_H)  pixel y to VGA adapter.
REQ-019 colour  out  COLOUR_BITS  pixel colour to VGA adapter.
REQ-020 plot  out  1  write strobe; x/y/colour are valid when it is high.
REQ-021 busy  out  1  high in ERASE, MOVE and DRAW.

Function
REQ-022 SHALL use FSM states IDLE, DRAW, WAIT, ERASE, MOVE. Transitions: IDLE->DRAW after 1 cycle; DRAW->WAIT after the last pixel; WAIT->ERASE when step_tick and enable; ERASE->MOVE after the last pixel; MOVE->DRAW after 1 cycle.
REQ-023 step_tick SHALL pulse 1 cycle every TICK_DIV*FRAMES_PER_STEP clocks; the tick generator runs regardless of state.
REQ-024 ERASE SHALL scan SPR_W*SPR_H pixels, one per cycle, row-major, at the old position; plot=1 each cycle; colour=bg_colour.
REQ-025 DRAW SHALL issue rom_addr 0..SPR_W*SPR_H-1, one per cycle. The matching x/y/plot SHALL appear 1 cycle later (pipeline latency 1). DRAW SHALL last SPR_W*SPR_H+1 cycles.
REQ-026 In DRAW, plot SHALL be 0 for any pixel whose rom_data equals TRANSPARENT; x/y SHALL still advance.
REQ-027 Pixel coordinates SHALL be pos_x+col, pos_y+row, with no wrap.
REQ-028 MOVE SHALL update pos_x and pos_y by +-1 according to dir_x and dir_y.
REQ-029 At x, a direction flip SHALL take effect in the same MOVE. When dir_x=right and pos_x==SCREEN_W-SPR_W: flip, pos_x-1. When dir_x=left and pos_x==0: flip, pos_x+1. Y follows the same rule with SCREEN_H-SPR_H.
REQ-030 If x and y hit boundaries in the same MOVE, both SHALL flip (corner bounce).
REQ-031 If SPR_W==SCREEN_W, pos_x SHALL stay fixed; same for y.
REQ-032 Deasserting enable SHALL NOT abort DRAW or ERASE. The block SHALL hold in WAIT; a step_tick missed while busy or disabled is dropped.
REQ-033 Outside ERASE and DRAW, plot SHALL be 0.

Reset
REQ-034 On resetn low: state=IDLE, pos=(X0,Y0), dir_x=right, dir_y=up (decreasing y), tick counters=0, plot=0, busy=0, x=0, y=0, colour=0, rom_addr=0.
REQ-035 Reset mid-DRAW/ERASE SHALL drop plot within the same cycle; no partial-frame recovery.

Structure
REQ-036 Package sprite_pkg SHALL hold the FSM state encodings and the clog2 function.
REQ-037 Sub-module frame_tick_gen(clock, resetn, tick) SHALL implement the TICK_DIV*FRAMES_PER_STEP divider.
REQ-038 The ROM SHALL be external; it is not instantiated inside this block.

Verification
REQ-039 Reset with defaults, model ROM all 7 -> first DRAW plots 64 pixels x 0..7, y 60..67; busy falls after 65 cycles.
REQ-040 TICK_DIV=4, FRAMES_PER_STEP=1, pos_x=152 moving right -> next MOVE gives pos_x=151 and dir_x=left.
REQ-041 Corner: X0=152, Y0=0, dir up/right -> one MOVE gives pos=(151,1), both directions flipped.
REQ-042 ROM pixel 9 = TRANSPARENT -> plot=0 exactly on the 10th DRAW pixel (col 1, row 1); all others plot=1.
REQ-043 enable=0 before the tick -> the block stays in WAIT with plot=0; re-enable -> ERASE starts on the next step_tick with colour=bg_colour.
REQ-044 resetn pulse mid-ERASE -> plot=0 immediately; after release, the DRAW at (X0,Y0) restarts.
